// File: rtl/falafel_pkg.sv
// falafel_pkg: shared types and constants for the falafel core <-> LSU path.
//   header_data_t      : one free-list header {addr, size, next_addr}
//   header_data_req_t  : core -> LSU request {val, lsu_op, header_data}
//   header_data_rsp_t  : LSU -> core response {val, header_data}
//   req_lsu_op_e       : LOCK, UNLOCK, LOAD, INSERT, DELETE
//   lsu_access()       : word access (we/addr/wdata) for a given op and step
package falafel_pkg;

  localparam int unsigned DATA_W = 64;

  // Allocator lock word location and the next_addr word offset within a header.
  localparam logic [DATA_W-1:0] LOCK_ADDR   = 64'h0;
  localparam logic [DATA_W-1:0] NEXT_OFFSET = 64'h8;

  typedef enum logic [2:0] {
    LOCK   = 3'd0,
    UNLOCK = 3'd1,
    LOAD   = 3'd2,
    INSERT = 3'd3,
    DELETE = 3'd4
  } req_lsu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] size;
    logic [DATA_W-1:0] next_addr;
  } header_data_t;

  typedef struct packed {
    logic         val;
    req_lsu_op_e  lsu_op;
    header_data_t header_data;
  } header_data_req_t;

  typedef struct packed {
    logic         val;
    header_data_t header_data;
  } header_data_rsp_t;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_access_t;

  // Word access performed by `op` at access index `step`. Address sums wrap.
  function automatic mem_access_t lsu_access(input req_lsu_op_e       op,
                                             input logic [1:0]        step,
                                             input header_data_t      hdr,
                                             input logic [DATA_W-1:0] lock_addr,
                                             input logic [DATA_W-1:0] next_offset);
    mem_access_t acc;
    acc = '0;
    case (op)
      LOAD: begin
        acc.we   = 1'b0;
        acc.addr = (step == 2'd0) ? hdr.addr : hdr.addr + next_offset;
      end
      INSERT: begin
        acc.we = 1'b1;
        if (step == 2'd0) begin
          acc.addr  = hdr.addr;
          acc.wdata = hdr.size;
        end else begin
          acc.addr  = hdr.addr + next_offset;
          acc.wdata = hdr.next_addr;
        end
      end
      DELETE: begin
        acc.we    = 1'b1;
        acc.addr  = hdr.addr + next_offset;
        acc.wdata = hdr.next_addr;
      end
      LOCK: begin
        // Step 0 polls the lock word, step 1 claims it.
        acc.we    = (step != 2'd0);
        acc.addr  = lock_addr;
        acc.wdata = (step != 2'd0) ? {{(DATA_W-1){1'b0}}, 1'b1} : {DATA_W{1'b0}};
      end
      UNLOCK: begin
        acc.we    = 1'b1;
        acc.addr  = lock_addr;
        acc.wdata = {DATA_W{1'b0}};
      end
      default: acc = '0;
    endcase
    return acc;
  endfunction

  // True when `step` is the final access of `op`.
  function automatic logic lsu_last_step(input req_lsu_op_e op, input logic [1:0] step);
    case (op)
      LOAD, INSERT, LOCK: lsu_last_step = (step == 2'd1);
      DELETE, UNLOCK:     lsu_last_step = (step == 2'd0);
      default:            lsu_last_step = 1'b1;
    endcase
  endfunction

  // True for the five defined ops; anything else responds without memory traffic.
  function automatic logic lsu_op_known(input req_lsu_op_e op);
    case (op)
      LOCK, UNLOCK, LOAD, INSERT, DELETE: lsu_op_known = 1'b1;
      default:                            lsu_op_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/falafel_lsu.sv
// falafel_lsu: load/store unit for falafel_core. Accepts one header-level
// request at a time, expands it into word accesses on a single-outstanding
// req/gnt/rvalid memory port and returns a one-cycle response.
// Ports:
//   clk_i, rst_ni     clock, synchronous active-low reset
//   req_from_core_i   request {val, lsu_op, header_data}
//   lsu_ready_o       high only in IDLE
//   rsp_to_core_o     response {val, header_data}, val pulses for one cycle
//   mem_req_o/we/addr/wdata  registered memory request, held until mem_gnt_i
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i  memory handshake and read data
module falafel_lsu #(
  parameter logic [falafel_pkg::DATA_W-1:0] LOCK_ADDR   = falafel_pkg::LOCK_ADDR,
  parameter logic [falafel_pkg::DATA_W-1:0] NEXT_OFFSET = falafel_pkg::NEXT_OFFSET
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  falafel_pkg::header_data_req_t  req_from_core_i,
  output logic                           lsu_ready_o,
  output falafel_pkg::header_data_rsp_t  rsp_to_core_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [falafel_pkg::DATA_W-1:0] mem_addr_o,
  output logic [falafel_pkg::DATA_W-1:0] mem_wdata_o,
  input  logic                           mem_gnt_i,
  input  logic                           mem_rvalid_i,
  input  logic [falafel_pkg::DATA_W-1:0] mem_rdata_i
);
  import falafel_pkg::*;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_e;

  lsu_state_e        state_r, state_s;
  logic [1:0]        step_q, step_s;
  req_lsu_op_e       op_r, op_s;
  header_data_t      hdr_r, hdr_s;
  mem_access_t       acc_s;
  logic              ready_r;
  header_data_rsp_t  rsp_r;
  logic              mem_req_r, mem_we_r;
  logic [DATA_W-1:0] mem_addr_r, mem_wdata_r;

  // Next-state, step and captured-header logic for the op sequencer.
  always_comb begin
    state_s = state_r;
    step_s  = step_q;
    op_s    = op_r;
    hdr_s   = hdr_r;
    case (state_r)
      S_IDLE: begin
        // ready_r is high in IDLE, so val alone qualifies acceptance here.
        if (req_from_core_i.val) begin
          op_s   = req_from_core_i.lsu_op;
          hdr_s  = req_from_core_i.header_data;
          step_s = 2'd0;
          if (lsu_op_known(req_from_core_i.lsu_op)) begin
            state_s = S_ISSUE;
          end else begin
            state_s = S_RESP;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (mem_gnt_i) begin
          state_s = S_WAIT;
        end else begin
          state_s = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          if (op_r == LOAD) begin
            if (step_q == 2'd0) begin
              hdr_s.size = mem_rdata_i;
            end else begin
              hdr_s.next_addr = mem_rdata_i;
            end
          end else begin
            hdr_s = hdr_r;
          end
          // A held lock keeps the sequencer spinning on the same poll.
          if ((op_r == LOCK) && (step_q == 2'd0) && (mem_rdata_i != {DATA_W{1'b0}})) begin
            state_s = S_ISSUE;
          end else if (lsu_last_step(op_r, step_q)) begin
            state_s = S_RESP;
          end else begin
            step_s  = step_q + 2'd1;
            state_s = S_ISSUE;
          end
        end else begin
          state_s = S_WAIT;
        end
      end
      S_RESP:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
    acc_s = lsu_access(op_s, step_s, hdr_s, LOCK_ADDR, NEXT_OFFSET);
  end

  // State, captured request and registered outputs decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r     <= S_IDLE;
      step_q      <= 2'd0;
      op_r        <= LOCK;
      hdr_r       <= '0;
      ready_r     <= 1'b1;
      rsp_r       <= '0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {DATA_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r                 <= state_s;
      step_q                  <= step_s;
      op_r                    <= op_s;
      hdr_r                   <= hdr_s;
      ready_r                 <= (state_s == S_IDLE);
      rsp_r.val               <= (state_s == S_RESP);
      rsp_r.header_data       <= (state_s == S_RESP) ? hdr_s : '0;
      mem_req_r               <= (state_s == S_ISSUE);
      mem_we_r                <= (state_s == S_ISSUE) && acc_s.we;
      mem_addr_r              <= (state_s == S_ISSUE) ? acc_s.addr : {DATA_W{1'b0}};
      mem_wdata_r             <= (state_s == S_ISSUE) ? acc_s.wdata : {DATA_W{1'b0}};
    end
  end

  assign lsu_ready_o   = ready_r;
  assign rsp_to_core_o = rsp_r;
  assign mem_req_o     = mem_req_r;
  assign mem_we_o      = mem_we_r;
  assign mem_addr_o    = mem_addr_r;
  assign mem_wdata_o   = mem_wdata_r;

endmodule

// File: tb/tb_falafel_lsu.sv
// Bench for falafel_lsu: directed requests against a bench-side memory with
// programmable grant/rvalid delays, and a reference model that predicts the
// access list, response header, response cycle and ready profile per request.
module tb_falafel_lsu;
  import falafel_pkg::*;

  logic             clk = 1'b0;
  logic             rst_ni;
  header_data_req_t req;
  logic             ready;
  header_data_rsp_t rsp;
  logic             mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [63:0]      mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  falafel_lsu dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .req_from_core_i (req),
    .lsu_ready_o     (ready),
    .rsp_to_core_o   (rsp),
    .mem_req_o       (mem_req),
    .mem_we_o        (mem_we),
    .mem_addr_o      (mem_addr),
    .mem_wdata_o     (mem_wdata),
    .mem_gnt_i       (mem_gnt),
    .mem_rvalid_i    (mem_rvalid),
    .mem_rdata_i     (mem_rdata)
  );

  typedef struct {logic we; logic [63:0] addr; logic [63:0] wdata;} acc_t;
  typedef struct {int cyc; header_data_t hdr;} rsp_t;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           g_dly = 0, r_dly = 0, lock_busy = 0;
  int           acc_cyc = 0, rsp_cyc = 0, free_cyc = 0, num_rsp = 0;
  bit           active = 1'b0, run_chk = 1'b0;
  logic [63:0]  mem [logic [63:0]];
  acc_t         exp_acc[$];
  acc_t         act_acc[$];
  rsp_t         exp_rsp[$];
  header_data_t last_rsp = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 64'd0;
  endfunction

  // ---------------- memory responder ----------------
  logic        pend = 1'b0;
  int          pcnt = 0, gcnt = 0;
  logic [63:0] prd = 64'd0;

  always @(negedge clk) begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (pend) begin
      if (pcnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = prd;
        pend       = 1'b0;
      end else begin
        pcnt--;
      end
    end else if (rst_ni && mem_req) begin
      if (gcnt < g_dly) begin
        gcnt++;
      end else begin
        mem_gnt = 1'b1;
        gcnt    = 0;
        act_acc.push_back('{mem_we, mem_addr, mem_wdata});
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          prd = 64'd0;
        end else begin
          prd = rd(mem_addr);
          if (mem_addr == 64'd0 && lock_busy > 0) begin
            lock_busy--;
            if (lock_busy == 0) mem[64'd0] = 64'd0;
          end
        end
        pend = 1'b1;
        pcnt = r_dly;
      end
    end
  end

  // ---------------- compare process ----------------
  logic        gnt_at_edge = 1'b0;
  logic        prev_req = 1'b0, prev_we = 1'b0, exp_ready;
  logic [63:0] prev_addr = 64'd0, prev_wdata = 64'd0;
  acc_t        a_act, a_exp;
  rsp_t        r_exp;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    gnt_at_edge <= mem_gnt;
  end

  always @(negedge clk) begin
    if (run_chk) begin
      exp_ready = !(active && cyc > acc_cyc && cyc <= rsp_cyc);
      chk("lsu_ready", {63'd0, ready}, {63'd0, exp_ready});
      if (rsp.val) begin
        num_rsp++;
        last_rsp = rsp.header_data;
        if (exp_rsp.size() == 0) begin
          chk("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          r_exp = exp_rsp.pop_front();
          chk("rsp_cycle", cyc, r_exp.cyc);
          chk("rsp_addr", rsp.header_data.addr, r_exp.hdr.addr);
          chk("rsp_size", rsp.header_data.size, r_exp.hdr.size);
          chk("rsp_next", rsp.header_data.next_addr, r_exp.hdr.next_addr);
        end
      end
      while (act_acc.size() > 0) begin
        a_act = act_acc.pop_front();
        if (exp_acc.size() == 0) begin
          chk("unexpected_access", a_act.addr, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          a_exp = exp_acc.pop_front();
          chk("acc_we", {63'd0, a_act.we}, {63'd0, a_exp.we});
          chk("acc_addr", a_act.addr, a_exp.addr);
          if (a_exp.we) chk("acc_wdata", a_act.wdata, a_exp.wdata);
        end
      end
      if (prev_req && !gnt_at_edge && rst_ni) begin
        chk("req_held", {63'd0, mem_req}, 64'd1);
        chk("req_we_held", {63'd0, mem_we}, {63'd0, prev_we});
        chk("req_addr_held", mem_addr, prev_addr);
        chk("req_wdata_held", mem_wdata, prev_wdata);
      end
      prev_req   = mem_req;
      prev_we    = mem_we;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
    end
  end

  // ---------------- stimulus + model ----------------
  task automatic send(input req_lsu_op_e op, input logic [63:0] a, input logic [63:0] s,
                      input logic [63:0] n, input int spins);
    header_data_t h, rh;
    int t, nacc;
    @(negedge clk);
    while (cyc < free_cyc) @(negedge clk);
    h = '{a, s, n};
    req.val = 1'b1;
    req.lsu_op = op;
    req.header_data = h;
    t = cyc;
    rh = h;
    nacc = 0;
    case (op)
      LOAD: begin
        exp_acc.push_back('{1'b0, a, 64'd0});
        exp_acc.push_back('{1'b0, a + 64'd8, 64'd0});
        rh.size = rd(a);
        rh.next_addr = rd(a + 64'd8);
        nacc = 2;
      end
      INSERT: begin
        exp_acc.push_back('{1'b1, a, s});
        exp_acc.push_back('{1'b1, a + 64'd8, n});
        nacc = 2;
      end
      DELETE: begin
        exp_acc.push_back('{1'b1, a + 64'd8, n});
        nacc = 1;
      end
      UNLOCK: begin
        exp_acc.push_back('{1'b1, 64'd0, 64'd0});
        nacc = 1;
      end
      LOCK: begin
        for (int i = 0; i <= spins; i++) exp_acc.push_back('{1'b0, 64'd0, 64'd0});
        exp_acc.push_back('{1'b1, 64'd0, 64'd1});
        nacc = spins + 2;
      end
      default: nacc = 0;
    endcase
    acc_cyc  = t;
    rsp_cyc  = t + 1 + nacc * (2 + g_dly + r_dly);
    free_cyc = rsp_cyc + 1;
    active   = 1'b1;
    exp_rsp.push_back('{rsp_cyc, rh});
    @(negedge clk);
    req.val = 1'b0;
  endtask

  task automatic wait_done();
    while (cyc <= rsp_cyc) @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, {63'd0, ready}, 64'd1);
    chk({tag, "_rsp_val"}, {63'd0, rsp.val}, 64'd0);
    chk({tag, "_rsp_addr"}, rsp.header_data.addr, 64'd0);
    chk({tag, "_rsp_size"}, rsp.header_data.size, 64'd0);
    chk({tag, "_rsp_next"}, rsp.header_data.next_addr, 64'd0);
    chk({tag, "_mem_req"}, {63'd0, mem_req}, 64'd0);
    chk({tag, "_mem_we"}, {63'd0, mem_we}, 64'd0);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
  endtask

  initial begin
    rst_ni     = 1'b0;
    req        = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 64'd0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst_ni  = 1'b1;
    run_chk = 1'b1;

    // LOAD with zero-wait memory
    mem[64'h10] = 64'h100;
    mem[64'h18] = 64'h200;
    send(LOAD, 64'h10, 64'd0, 64'd0, 0);
    wait_done();
    chk("load_addr", last_rsp.addr, 64'h10);
    chk("load_size", last_rsp.size, 64'h100);
    chk("load_next", last_rsp.next_addr, 64'h200);

    // INSERT
    send(INSERT, 64'h80, 64'h40, 64'h300, 0);
    wait_done();
    chk("insert_mem_size", rd(64'h80), 64'h40);
    chk("insert_mem_next", rd(64'h88), 64'h300);
    chk("insert_rsp_size", last_rsp.size, 64'h40);

    // LOCK with the word held for three polls
    mem[64'h0] = 64'd1;
    lock_busy  = 3;
    send(LOCK, 64'h0, 64'd0, 64'd0, 3);
    wait_done();
    chk("lock_word_taken", rd(64'h0), 64'd1);

    // DELETE and UNLOCK with grant delayed two cycles
    g_dly = 2;
    send(DELETE, 64'h40, 64'd0, 64'h55, 0);
    send(UNLOCK, 64'h0, 64'd0, 64'd0, 0);
    wait_done();
    chk("delete_mem", rd(64'h48), 64'h55);
    chk("unlock_mem", rd(64'h0), 64'd0);
    g_dly = 0;

    // A request held high during a busy LOAD is taken only back in IDLE
    send(LOAD, 64'h80, 64'd0, 64'd0, 0);
    req.val = 1'b1;
    req.lsu_op = DELETE;
    req.header_data = '{64'h60, 64'd0, 64'h77};
    send(DELETE, 64'h60, 64'd0, 64'h77, 0);
    wait_done();
    chk("busy_delete_mem", rd(64'h68), 64'h77);

    // Undefined op responds one cycle after acceptance
    send(req_lsu_op_e'(3'd7), 64'h123, 64'h4, 64'h5, 0);
    wait_done();
    chk("undef_rsp_addr", last_rsp.addr, 64'h123);

    // Reset while a LOAD waits on a slow read
    r_dly = 3;
    send(LOAD, 64'h10, 64'd0, 64'd0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b0;
    @(posedge clk);
    active = 1'b0;
    free_cyc = 0;
    rsp_cyc = 0;
    exp_acc.delete();
    exp_rsp.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    chk_reset_state("midop_reset");
    repeat (3) @(negedge clk);
    r_dly = 0;
    send(LOAD, 64'h80, 64'd0, 64'd0, 0);
    wait_done();
    chk("post_reset_size", last_rsp.size, 64'h40);
    chk("post_reset_next", last_rsp.next_addr, 64'h300);

    // Drain: every predicted response and access must have been seen
    for (int i = 0; i < 50 && (exp_rsp.size() > 0 || act_acc.size() > 0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("rsp_left", exp_rsp.size(), 64'd0);
    chk("acc_left", exp_acc.size(), 64'd0);
    chk("rsp_count", num_rsp, 64'd9);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/falafel_lsu.md
# falafel_lsu

Load/store unit serving `falafel_core`: accepts one header-level request at a time (LOCK, UNLOCK, LOAD, INSERT, DELETE), expands it into one or more word accesses on a single-outstanding memory port, and returns a one-cycle response. It is the responder end of the core↔LSU request/response interface and the only block that touches free-list memory.

## Interface
- `DATA_W`, 64 (from `falafel_pkg`): word/address width
- `LOCK_ADDR`, `'h0`: byte address of the allocator lock word
- `NEXT_OFFSET`, 8: byte offset of the `next_addr` word within a header; `size` sits at offset 0

- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; synchronous, active-low
- `req_from_core_i`  in  `header_data_req_t`  request: `val`, `lsu_op`, `header_data{addr,size,next_addr}`
- `lsu_ready_o`  out  1  LSU can accept a request this cycle
- `rsp_to_core_o`  out  `header_data_rsp_t`  response: `val`, `header_data`
- `mem_req_o`  out  1  memory access request
- `mem_we_o`  out  1  1 = write, 0 = read
- `mem_addr_o`  out  DATA_W  byte address
- `mem_wdata_o`  out  DATA_W  write data
- `mem_gnt_i`  in  1  access accepted
- `mem_rvalid_i`  in  1  access complete; read data valid for reads, write ack for writes
- `mem_rdata_i`  in  DATA_W  read data

## Operation
- States: IDLE, ISSUE, WAIT, RESP; `step_q` (2 bits) selects the access within an op.
- IDLE: `lsu_ready_o`=1. On `val && lsu_ready_o`: capture op and header, `step_q`=0, go ISSUE. `val` while not ready is ignored.
- ISSUE: drive `mem_req_o`=1 with addr/we/wdata for the current step; hold all fields stable until `mem_gnt_i`; then go WAIT.
- WAIT: on `mem_rvalid_i`: store read data if a read, then either advance `step_q` → ISSUE, or go RESP.
- RESP: `rsp_to_core_o.val`=1 for exactly one cycle, → IDLE.
- Access sequences (A = captured `addr`):
  - LOAD: read A → `size`; read A+NEXT_OFFSET → `next_addr`; response header = {A, size, next_addr}.
  - INSERT: write `size` to A; write `next_addr` to A+NEXT_OFFSET.
  - DELETE: write `next_addr` to A+NEXT_OFFSET (relinks the predecessor).
  - LOCK: read LOCK_ADDR; if nonzero, re-issue the same read (spin, unbounded); if zero, write 1 to LOCK_ADDR.
  - UNLOCK: write 0 to LOCK_ADDR.
  - Undefined op: no memory access, IDLE → RESP directly.
- Response `header_data` is the loaded header for LOAD and the captured request header for all other ops.
- Address arithmetic is DATA_W-bit modulo; A+NEXT_OFFSET wraps silently.
- Lock exclusivity relies on this LSU being the sole master on its memory port.

## Timing
- Reset: state IDLE, `lsu_ready_o`=1, `rsp_to_core_o`='0, `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `step_q`=0.
- Outputs are registered or state-decoded; no combinational path from `req_from_core_i` to `mem_*`.
- `lsu_ready_o` is 0 from the cycle after acceptance through RESP inclusive.
- `mem_rvalid_i` is sampled only in WAIT, and never in the same cycle as its grant. Responses arriving in other states are ignored.
- Zero-wait memory (grant in the ISSUE cycle, rvalid the next cycle), accept at T: two-access ops (LOAD, INSERT, uncontended LOCK) respond at T+5; one-access ops (DELETE, UNLOCK) at T+3; undefined op at T+1. Each extra wait cycle on gnt or rvalid adds one cycle.
- Reset mid-operation: next cycle is IDLE with `mem_req_o`=0; any late `mem_rvalid_i` is dropped.

## Structure
- `falafel_pkg` holds `header_data_t`, `header_data_req_t`, `header_data_rsp_t`, `req_lsu_op_e` (LOCK, UNLOCK, LOAD, INSERT, DELETE), and `DATA_W`. Add `LOCK_ADDR` and `NEXT_OFFSET` defaults as package constants.
- The LSU FSM state enum is local to the module.
- One optional sub-module, `falafel_mem_port`, runs a single req/gnt/rvalid transaction (ISSUE/WAIT) and returns done + rdata. The op sequencer lives in `falafel_lsu`.

## Test plan
- Memory preloaded with [0x10]=0x100 and [0x18]=0x200; LOAD A=0x10 with zero-wait memory → `rsp.val` at T+5 with header {0x10, 0x100, 0x200}; exactly two reads, at 0x10 then 0x18.
- INSERT {0x80, 0x40, 0x300} → writes [0x80]=0x40 then [0x88]=0x300; `rsp.val` at T+5 carrying the request header.
- Lock word = 1 for 3 reads, then cleared by the bench; issue LOCK → four reads of 0x0, then a write of 1; exactly one `rsp.val`; `lsu_ready_o` stays 0 throughout.
- DELETE then UNLOCK with `mem_gnt_i` delayed 2 cycles → `mem_req_o` and its fields are held stable; responses at T+5 each; final memory state is [A+8]=next_addr and [0x0]=0.
- Request `val` asserted during a busy LOAD → ignored, with no extra memory access; the request is accepted only once back in IDLE.
- `rst_ni` low while in WAIT of a LOAD, with `mem_rvalid_i` arriving after reset → all outputs at reset values, no `rsp.val`, and the next request is handled normally.
